// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants, register offsets and FSM encoding for the interrupt controller
package int_ctrl_pkg;
   localparam int NUM_SRC = 6;
   localparam logic [3:0] REG_EDGE    = 4'h0;
   localparam logic [3:0] REG_ENABLE  = 4'h4;
   localparam logic [3:0] REG_PENDING = 4'h8;
   localparam logic [3:0] REG_STATUS  = 4'hC;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;
   function automatic logic [NUM_SRC-1:0] onehot(input logic [2:0] idx);
      return NUM_SRC'(1) << idx;
   endfunction
endpackage

// File: rtl/int_ctrl_prio.sv
// prio_enc6: fixed-priority encoder, lowest set bit wins
//   req   in  6-bit request vector
//   idx   out index of the lowest set request bit
//   valid out any request bit set
module prio_enc6 (
   input  logic [5:0] req,
   output logic [2:0] idx,
   output logic       valid
);
   always_comb begin
      valid = |req;
      idx   = req[0] ? 3'd0 :
              req[1] ? 3'd1 :
              req[2] ? 3'd2 :
              req[3] ? 3'd3 :
              req[4] ? 3'd4 : 3'd5;
   end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge/level interrupt controller with fixed priority and a CP0 handshake
//   clk, reset   clock; asynchronous active-low reset
//   irq_src      raw peripheral interrupt lines
//   WE/addr/WD   bus write port (EDGE, ENABLE, PENDING w1c, STATUS ro)
//   RD           combinational bus read data selected by addr[3:2]
//   IntAck       CP0 took the interrupt; EXLclr handler finished (eret)
//   HWInt        registered one-hot request to CP0; busy = FSM not idle
module int_ctrl #(
   parameter int NUM_SRC = int_ctrl_pkg::NUM_SRC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               WE,
   input  logic [3:0]         addr,
   input  logic [31:0]        WD,
   output logic [31:0]        RD,
   input  logic               IntAck,
   input  logic               EXLclr,
   output logic [NUM_SRC-1:0] HWInt,
   output logic               busy
);
   import int_ctrl_pkg::*;
   logic [NUM_SRC-1:0] edge_q, edge_d, enable_q, enable_d, pending_q, pending_d;
   logic [NUM_SRC-1:0] prev_q, hwint_q, hwint_d, clr, set_edge;
   logic [2:0]         sel_q, sel_d, win_idx;
   logic               win_valid, wr_edge, wr_enable, wr_pending, ack;
   state_t             state_q, state_d;
   logic               unused_bits;
   assign unused_bits = ^{addr[1:0], WD[31:NUM_SRC]};
   prio_enc6 u_prio (
      .req   (pending_q & enable_q),
      .idx   (win_idx),
      .valid (win_valid)
   );
   always_comb begin
      wr_edge    = WE && addr[3:2] == REG_EDGE[3:2];
      wr_enable  = WE && addr[3:2] == REG_ENABLE[3:2];
      wr_pending = WE && addr[3:2] == REG_PENDING[3:2];
      ack        = state_q == ST_ASSERT && IntAck;
      edge_d     = wr_edge ? WD[NUM_SRC-1:0] : edge_q;
      enable_d   = wr_enable ? WD[NUM_SRC-1:0] : enable_q;
      // Acknowledge consumes the edge-latched request of the selected source.
      clr        = (wr_pending ? WD[NUM_SRC-1:0] : '0) | (ack ? onehot(sel_q) : '0);
      set_edge   = irq_src & ~prev_q;
      // Set beats clear in edge mode; level-mode bits simply mirror the line.
      pending_d  = (edge_q & (set_edge | (pending_q & ~clr))) | (~edge_q & irq_src);
   end
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      hwint_d = hwint_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_ASSERT;
               sel_d   = win_idx;
               hwint_d = onehot(win_idx);
            end
         end
         ST_ASSERT: begin
            // Ack wins over withdrawal; no preemption while asserting.
            if (IntAck) begin
               state_d = ST_SERVICE;
               hwint_d = '0;
            end else if (!(pending_q[sel_q] && enable_q[sel_q])) begin
               state_d = ST_IDLE;
               hwint_d = '0;
            end
         end
         ST_SERVICE: begin
            if (EXLclr) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            hwint_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_q    <= '0;
         enable_q  <= '0;
         pending_q <= '0;
         prev_q    <= '0;
         sel_q     <= '0;
         hwint_q   <= '0;
         state_q   <= ST_IDLE;
      end else begin
         edge_q    <= edge_d;
         enable_q  <= enable_d;
         pending_q <= pending_d;
         prev_q    <= irq_src;
         sel_q     <= sel_d;
         hwint_q   <= hwint_d;
         state_q   <= state_d;
      end
   end
   always_comb begin
      RD = addr[3:2] == REG_EDGE[3:2]    ? 32'(edge_q) :
           addr[3:2] == REG_ENABLE[3:2]  ? 32'(enable_q) :
           addr[3:2] == REG_PENDING[3:2] ? 32'(pending_q) :
                                           32'({state_q, 1'b0, sel_q});
   end
   assign HWInt = hwint_q;
   assign busy  = state_q != ST_IDLE;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and randomized checks of int_ctrl against a behavioural model
module tb_int_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  irq_src = '0;
   logic        WE = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] WD = '0;
   logic [31:0] RD;
   logic        IntAck = 1'b0;
   logic        EXLclr = 1'b0;
   logic [5:0]  HWInt;
   logic        busy;
   int          tests = 0;
   int          fails = 0;
   logic [5:0]  m_prev, m_pend, m_en, m_edge, m_hw;
   int          m_state, m_sel;

   int_ctrl dut (
      .clk(clk), .reset(reset), .irq_src(irq_src), .WE(WE), .addr(addr), .WD(WD),
      .RD(RD), .IntAck(IntAck), .EXLclr(EXLclr), .HWInt(HWInt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_en = '0; m_edge = '0; m_hw = '0;
      m_state = 0; m_sel = 0;
   endtask

   function automatic logic [31:0] model_rd(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return 32'(m_edge);
         2'd1:    return 32'(m_en);
         2'd2:    return 32'(m_pend);
         default: return (32'(m_state) << 4) | 32'(m_sel);
      endcase
   endfunction

   // One rising edge of the controller, computed from the rules with integers.
   task automatic model_edge();
      logic [5:0] np;
      int ns, nsel, win;
      logic [5:0] nhw;
      np = '0; ns = m_state; nsel = m_sel; nhw = m_hw; win = -1;
      for (int i = 0; i < 6; i++) begin
         if (m_pend[i] && m_en[i] && win < 0) win = i;
         if (!m_edge[i]) np[i] = irq_src[i];
         else if (irq_src[i] && !m_prev[i]) np[i] = 1'b1;
         else if ((WE && addr[3:2] == 2'd2 && WD[i]) || (m_state == 1 && IntAck && m_sel == i)) np[i] = 1'b0;
         else np[i] = m_pend[i];
      end
      if (m_state == 0 && win >= 0) begin
         ns = 1; nsel = win; nhw = 6'(1) << win;
      end else if (m_state == 1 && IntAck) begin
         ns = 2; nhw = '0;
      end else if (m_state == 1 && !(m_pend[m_sel] && m_en[m_sel])) begin
         ns = 0; nhw = '0;
      end else if (m_state == 2 && EXLclr) begin
         ns = 0;
      end
      if (WE && addr[3:2] == 2'd0) m_edge = WD[5:0];
      if (WE && addr[3:2] == 2'd1) m_en = WD[5:0];
      m_prev = irq_src; m_pend = np; m_state = ns; m_sel = nsel; m_hw = nhw;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("hwint", 32'(HWInt), 32'(m_hw));
      chk("busy", 32'(busy), 32'(m_state != 0));
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      WE = 1'b1; addr = a; WD = d;
      step();
      WE = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, RD, exp);
      chk({tag, "_model"}, RD, model_rd(a));
   endtask

   initial begin
      model_reset();
      #12 reset = 1'b1;
      rdchk("rst_status", 4'hC, 32'h0);
      // edge path
      wr(4'h4, 32'h3F);
      wr(4'h0, 32'h04);
      irq_src = 6'h04; step();
      rdchk("edge_pend", 4'h8, 32'h04);
      chk("edge_hw_wait", 32'(HWInt), 32'h0);
      irq_src = 6'h00; step();
      chk("edge_hw", 32'(HWInt), 32'h04);
      IntAck = 1'b1; step(); IntAck = 1'b0;
      chk("edge_ack_hw", 32'(HWInt), 32'h0);
      rdchk("edge_ack_pend", 4'h8, 32'h0);
      rdchk("edge_service", 4'hC, 32'h22);
      EXLclr = 1'b1; step(); EXLclr = 1'b0;
      rdchk("edge_idle", 4'hC, 32'h02);
      // priority, level mode
      wr(4'h0, 32'h00);
      irq_src = 6'h22; step(); step();
      chk("prio_hw", 32'(HWInt), 32'h02);
      rdchk("prio_status", 4'hC, 32'h11);
      IntAck = 1'b1; irq_src = 6'h20; step(); IntAck = 1'b0;
      EXLclr = 1'b1; step(); EXLclr = 1'b0;
      step();
      chk("prio_next_hw", 32'(HWInt), 32'h20);
      irq_src = 6'h00; step(); step();
      chk("prio_drop_hw", 32'(HWInt), 32'h0);
      // withdrawal
      irq_src = 6'h08; step(); step();
      chk("wd_hw", 32'(HWInt), 32'h08);
      irq_src = 6'h00; step(); step();
      chk("wd_hw_off", 32'(HWInt), 32'h0);
      chk("wd_busy", 32'(busy), 32'h0);
      // masking and write-1-to-clear collision
      wr(4'h4, 32'h00);
      wr(4'h0, 32'h01);
      irq_src = 6'h01; step(); step();
      rdchk("mask_pend", 4'h8, 32'h01);
      chk("mask_hw", 32'(HWInt), 32'h0);
      irq_src = 6'h00; step();
      irq_src = 6'h01; wr(4'h8, 32'h01);
      rdchk("w1c_setwins", 4'h8, 32'h01);
      wr(4'h8, 32'h01);
      rdchk("w1c_clear", 4'h8, 32'h00);
      irq_src = 6'h00; step();
      irq_src = 6'h01; step();
      // stray handshakes
      IntAck = 1'b1; step(); IntAck = 1'b0;
      chk("stray_ack_busy", 32'(busy), 32'h0);
      wr(4'h4, 32'h01);
      step();
      chk("stray_assert_hw", 32'(HWInt), 32'h01);
      EXLclr = 1'b1; step(); EXLclr = 1'b0;
      rdchk("stray_exl_state", 4'hC, 32'h10);
      chk("stray_exl_hw", 32'(HWInt), 32'h01);
      // asynchronous reset while asserting
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_hw", 32'(HWInt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      for (int a = 0; a < 4; a++) rdchk("rst_reg", 4'(a * 4), 32'h0);
      reset = 1'b1;
      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         irq_src = ($urandom % 4 == 0) ? 6'($urandom) : irq_src;
         WE      = ($urandom % 10 == 0);
         addr    = 4'($urandom);
         WD      = $urandom;
         IntAck  = ($urandom % 3 == 0);
         EXLclr  = ($urandom % 4 == 0);
         step();
         WE = 1'b0; IntAck = 1'b0; EXLclr = 1'b0;
         addr = 4'($urandom);
         #1;
         chk("rand_rd", RD, model_rd(addr));
         chk("rand_onehot", 32'($countones(HWInt) <= 1), 32'h1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 6: number of interrupt sources, equal to the CP0 HWInt width.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 irq_src  input  6  raw interrupt lines from peripherals, synchronous to clk.
REQ-005 WE  input  1  bus write enable for the control registers.
REQ-006 addr  input  4  byte address; addr[3:2] selects the register, addr[1:0] ignored.
REQ-007 WD  input  32  bus write data.
REQ-008 RD  output  32  bus read data, combinational from addr.
REQ-009 IntAck  input  1  CP0 accepted an interrupt this cycle (Req high and interrupt cause selected).
REQ-010 EXLclr  input  1  eret executed; the handler is finished.
REQ-011 HWInt  output  6  registered one-hot interrupt request to CP0.
REQ-012 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-013 Register map SHALL be: 0x0 EDGE (1 = edge mode, 0 = level mode), 0x4 ENABLE, 0x8 PENDING, 0xC STATUS; bits [31:6] read as 0.
REQ-014 EDGE and ENABLE SHALL be written from WD[5:0] when WE=1.
REQ-015 A PENDING write SHALL be write-1-to-clear; STATUS SHALL be read-only.
REQ-016 STATUS SHALL read [2:0] = selected index and [5:4] = state (IDLE=0, ASSERT=1, SERVICE=2).
REQ-017 prev[5:0] SHALL register irq_src every cycle.
REQ-018 In edge mode, PENDING[i] SHALL be set on an edge where irq_src[i]=1 and prev[i]=0.
REQ-019 In level mode, PENDING[i] SHALL follow irq_src[i].
REQ-020 If a set and a software clear of the same bit occur in one cycle, the set SHALL win.
REQ-021 Eligible sources SHALL be PENDING & ENABLE; the lowest index SHALL have the highest priority (fixed priority).
REQ-022 IDLE -> ASSERT: on the edge where any source is eligible, latch sel = highest-priority index and set HWInt = one-hot(sel).
REQ-023 Latency: source rising before edge k gives PENDING at edge k and HWInt visible after edge k+1.
REQ-024 ASSERT -> SERVICE on IntAck: HWInt <= 0; PENDING[sel] cleared if edge mode.
REQ-025 ASSERT -> IDLE if PENDING[sel] or ENABLE[sel] drops before IntAck (software clear, disable, level source released): HWInt <= 0, no ack.
REQ-026 In ASSERT, HWInt SHALL stay fixed even if a higher-priority source becomes eligible (no preemption).
REQ-027 SERVICE -> IDLE on EXLclr; new eligible sources wait in PENDING meanwhile.
REQ-028 IntAck outside ASSERT and EXLclr outside SERVICE SHALL be ignored.
REQ-029 If IntAck and EXLclr occur together in ASSERT, IntAck SHALL take effect and EXLclr is ignored.
REQ-030 HWInt SHALL have at most one bit set at any time.
REQ-031 busy SHALL be high when state != IDLE.
REQ-032 Bus writes SHALL be accepted in every state.

Reset
REQ-033 While reset=0, these SHALL clear asynchronously: EDGE, ENABLE, PENDING, prev, sel, HWInt; state SHALL go to IDLE.
REQ-034 After reset, HWInt=0, busy=0, RD of all registers = 0.
REQ-035 Reset asserted in ASSERT or SERVICE SHALL drop HWInt at once; no ack or EXLclr is needed afterwards.

Structure
REQ-036 A shared package SHALL hold:
- NUM_SRC;
- the register offsets (EDGE/ENABLE/PENDING/STATUS);
- the state encoding IDLE/ASSERT/SERVICE.
REQ-037 The priority selection SHALL be one sub-module, prio_enc6: 6-bit request in, 3-bit index plus valid out, combinational.

Verification
REQ-038 Reset values: reset=0 mid-ASSERT -> HWInt=0, busy=0, all register reads 0.
REQ-039 Edge path: ENABLE=0x3F, EDGE=0x04; pulse irq_src[2] one cycle -> PENDING=0x04, HWInt=0x04 one edge later; IntAck -> HWInt=0, PENDING=0, state SERVICE; EXLclr -> IDLE.
REQ-040 Priority: irq_src=0x22 simultaneous, all enabled, level mode -> HWInt=0x02, STATUS[2:0]=1; after ack and EXLclr with source 1 low -> HWInt=0x20.
REQ-041 Withdrawal: level source 3 high, HWInt=0x08; drop irq_src[3] before IntAck -> HWInt=0, state IDLE.
REQ-042 Masking and W1C: ENABLE=0x00, edge on source 0 -> PENDING=0x01, HWInt stays 0; write PENDING=0x01 the same cycle as a new edge -> PENDING stays 0x01.
REQ-043 Stray handshake: IntAck in IDLE and EXLclr in ASSERT -> no state change.
